// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and buffers
// {pc, inst} pairs for decode. Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic          run;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_inst [QUEUE_DEPTH];
  logic [31:0]   fifo_pc   [QUEUE_DEPTH];

  logic [CW:0]   in_use;
  logic [31:0]   target;
  logic          grant;
  logic          dropping;
  logic          fifo_empty;
  logic          accept;
  logic          push;
  logic          pop_fifo;

  // Every buffered entry and every fetch still in flight holds one credit, so a response always has room.
  assign in_use     = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o = run & (in_use < (CW+1)'(QUEUE_DEPTH)) & ~redirect_i;
  assign imem_addr_o = pc;
  assign target     = {redirect_pc_i[31:2], 2'b00};
  assign grant      = imem_req_o & imem_gnt_i;
  assign dropping   = (drop != '0);
  assign fifo_empty = (count == '0);
  assign accept     = imem_rvalid_i & ~dropping & ~redirect_i;
  assign pop_fifo   = ~fifo_empty & inst_ready_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass       = fifo_empty & accept;
  assign push         = accept & ~(bypass & inst_ready_i);
  assign inst_valid_o = ~fifo_empty | bypass;

  always_comb begin
    inst_o    = '0;
    inst_pc_o = '0;
    if (!fifo_empty) begin
      inst_o    = fifo_inst[rd_ptr];
      inst_pc_o = fifo_pc[rd_ptr];
    end else if (bypass) begin
      inst_o    = imem_rdata_i;
      inst_pc_o = resp_pc;
    end
  end
`else
  assign push         = accept;
  assign inst_valid_o = ~fifo_empty;

  always_comb begin
    inst_o    = '0;
    inst_pc_o = '0;
    if (!fifo_empty) begin
      inst_o    = fifo_inst[rd_ptr];
      inst_pc_o = fifo_pc[rd_ptr];
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      run         <= 1'b0;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        // Whatever is still in flight after this cycle's response belongs to the old path.
        pc      <= target;
        resp_pc <= target;
        drop    <= outstanding - CW'(imem_rvalid_i);
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (grant)
          pc <= pc + 32'd4;
        if (imem_rvalid_i && dropping)
          drop <= drop - CW'(1);
        if (accept)
          resp_pc <= resp_pc + 32'd4;
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop_fifo)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop_fifo);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !redirect_i) begin
      fifo_inst[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with in-order responses,
// scoreboard of expected {pc, inst} pairs, plus a startup vector table.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ready;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    bit          gnt;
    bit          ready;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  flight_t     inflight[$];
  entry_t      exp_q[$];
  flight_t     cur;
  bit          cur_v;
  bit          stall;
  bit          run_m;
  logic [31:0] exp_fetch;
  int          n_checks;
  int          n_fail;
  int          n_grants;
  bit          watch_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
    gnt         = g;
    ready       = r;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  // One clock of the reference model: called #1 after a negedge, returns on the next negedge.
  task automatic tick();
    bit          grant;
    int          occ;
    logic [31:0] g_addr;
    entry_t      e;
    occ = exp_q.size() + inflight.size() + (cur_v ? 1 : 0);
    checkOutput("imem_req", imem_req, run_m && (occ < DEPTH) && !redirect);
`ifndef FETCH_BYPASS_EN
    checkOutput("inst_valid", inst_valid, exp_q.size() != 0);
`endif
    grant  = imem_req && gnt;
    g_addr = imem_addr;
    if (grant) begin
      checkOutput("imem_addr", imem_addr, exp_fetch);
      n_grants++;
    end
    if (cur_v && !cur.stale && !redirect) begin
      e.pc   = cur.addr;
      e.inst = mem_word(cur.addr);
      exp_q.push_back(e);
    end
    if (inst_valid && ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pop", inst_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("inst_pc", inst_pc, e.pc);
        checkOutput("inst", inst, e.inst);
        if (watch_first) begin
          first_pc    = inst_pc;
          watch_first = 1'b0;
        end
      end
    end
    if (redirect) begin
      exp_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    if (grant) begin
      cur.addr  = g_addr;
      cur.stale = 1'b0;
      inflight.push_back(cur);
    end
    run_m = 1'b1;
    @(negedge clk);
    if (!stall && inflight.size() != 0) begin
      cur    = inflight.pop_front();
      cur_v  = 1'b1;
      rvalid = 1'b1;
      rdata  = mem_word(cur.addr);
    end else begin
      cur_v  = 1'b0;
      rvalid = 1'b0;
      rdata  = $urandom;
    end
  endtask

  task automatic step(input bit g, input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(g, r, 1'b0, 32'h0);
      tick();
    end
  endtask

  // Asynchronous reset: outputs must return to reset values without a clock edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    gnt      = 1'b0;
    ready    = 1'b0;
    redirect = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    #1;
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", inst_valid, 1'b0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_pc", inst_pc, 32'h0);
    inflight.delete();
    exp_q.delete();
    cur_v     = 1'b0;
    stall     = 1'b0;
    run_m     = 1'b0;
    exp_fetch = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[8];
    n_checks    = 0;
    n_fail      = 0;
    n_grants    = 0;
    watch_first = 1'b0;
    first_pc    = 32'hDEAD_DEAD;
    redirect_pc = '0;
    @(negedge clk);
    do_reset();

    // Backpressure: decode stalled, memory always granting.
    n_grants = 0;
    step(1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_grants", n_grants, 4);
    checkOutput("bp_req_low", imem_req, 1'b0);
    checkOutput("bp_valid", inst_valid, 1'b1);
    checkOutput("bp_head_pc", inst_pc, 32'h0);
    tick();
    step(1'b1, 1'b1, 12);

    // Redirect with two fetches outstanding.
    step(1'b0, 1'b1, 4);
    stall = 1'b1;
    step(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    tick();
    watch_first = 1'b1;
    first_pc    = 32'hDEAD_DEAD;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_addr", imem_addr, 32'h0000_0100);
    checkOutput("redir_req", imem_req, 1'b1);
    stall = 1'b0;
    tick();
    step(1'b1, 1'b1, 10);
    checkOutput("redir_first_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop.
    step(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    checkOutput("pre_redir_valid", inst_valid, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir2_valid", inst_valid, 1'b0);
    checkOutput("redir2_addr", imem_addr, 32'h0000_0200);
    tick();
    step(1'b1, 1'b1, 6);

    // PC wraparound at the top of the address space.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    tick();
    step(1'b1, 1'b1, 6);

    // Reset mid-burst, then the startup sequence from the vector table.
    do_reset();
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].gnt, vecs[i].ready, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
      checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      checkOutput($sformatf("vec%0d_valid", i), inst_valid, vecs[i].valid);
      checkOutput($sformatf("vec%0d_pc", i), inst_pc, vecs[i].pc);
      tick();
    end
    step(1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("final_empty", inst_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues in-order word requests to instruction memory over a request/grant + response-valid interface. Returned instructions are buffered, together with their PCs, in a small FIFO that feeds the decode stage through a valid/ready handshake. On a control-flow redirect it flushes buffered instructions and silently drops responses still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- QUEUE_DEPTH, 4, instruction FIFO entries; power of two, ≥2. It is also the maximum number of outstanding plus buffered fetches.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- rst_ni  input  1  reset; asynchronous, active-low
- redirect_i  input  1  taken jump/branch; load PC from redirect_pc_i, flush
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch word address (byte address, [1:0]=0)
- imem_gnt_i  input  1  request accepted this cycle (req & gnt = handshake)
- imem_rvalid_i  input  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata_i  input  32  response instruction word
- inst_valid_o  output  1  instruction available to decode
- inst_o  output  32  instruction word (decoder inst_i)
- inst_pc_o  output  32  PC of inst_o
- inst_ready_i  input  1  decode accepts inst_o this cycle

## Operation
- State: pc (32b), run flag, outstanding counter (0..QUEUE_DEPTH), drop counter (0..QUEUE_DEPTH), FIFO of {pc, inst} with rd/wr pointers and count. Pointers wrap modulo QUEUE_DEPTH.
- Credit: imem_req_o = run & (count + outstanding < QUEUE_DEPTH) & !redirect_i. imem_addr_o = pc.
- Grant: pc <= pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC → 0). outstanding++.
- Response: outstanding--. If drop > 0, then drop-- and discard the data. Otherwise push {fetch pc, rdata}. The fetch pc is tracked by a response-PC register that advances by 4 per accepted response.
- Pop: inst_valid_o & inst_ready_i removes the head entry.
- Redirect (highest priority):
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - FIFO count <= 0.
  - drop <= outstanding after this cycle's response decrement; a response in the redirect cycle is discarded.
  - Response-PC <= redirect target.
  - imem_req_o is forced low that cycle, so no grant can coincide with redirect.
  - A pop in the same cycle is still honoured by decode, but the FIFO is emptied regardless.
- Push and pop in the same cycle when full: allowed. Count is unchanged.
- Overflow cannot occur by construction: the credit rule guarantees space for every outstanding response.
- imem_req_o held with stable imem_addr_o until granted, unless redirected.

## Timing
- Reset (rst_ni low, asynchronous):
  - pc=RESET_PC, run=0, counters=0, FIFO empty.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- run sets on the first clock edge after rst_ni rises. The first request is asserted in the 2nd cycle after deassertion.
- Latency (bypass disabled): response in cycle N → inst_valid_o in cycle N+1.
- Redirect in cycle N: new address on imem_addr_o and imem_req_o high in cycle N+1. inst_valid_o=0 in N+1.
- Reset mid-operation clears all state immediately. A memory responding after reset must not be relied upon; verification does not drive rvalid without a prior grant.
- Throughput: 1 instruction/cycle sustained when memory grants every cycle and decode is always ready.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and drop==0, a response is presented combinationally on inst_o/inst_pc_o with inst_valid_o=1 in the same cycle. It is enqueued only if inst_ready_i=0. Latency is 0 cycles from rvalid.
- Not defined: all responses pass through the FIFO (1-cycle latency). There is no combinational path from imem_* inputs to inst_* outputs.

## Test plan
- Reset, then gnt=1 always, rvalid one cycle after each grant, ready=1 → addresses 0,4,8,…. inst_pc_o 0,4,8 on consecutive cycles. First inst_valid_o at cycle 4 after reset release (bypass off).
- ready=0 with memory always granting → exactly 4 grants, then imem_req_o=0. FIFO holds PCs 0..C. Set ready=1 → drains in order and requests resume.
- Redirect to 32'h0000_0103 with 2 fetches outstanding → next address 32'h0000_0100. Both stale responses dropped. First inst_pc_o after the redirect is 0x100.
- Redirect in the same cycle as an rvalid and a pop → the response is discarded and inst_valid_o=0 next cycle.
- PC=32'hFFFF_FFFC granted → next imem_addr_o=0.
- Assert rst_ni low mid-burst → outputs return to reset values within the same cycle and fetch restarts at RESET_PC.
